io_uart_in: RTL
===============

IO_UART_IN -- requirements
Module: io_uart_in

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, 4..64).
REQ-002 SHALL provide parameter BASE_ADR, default 14'h0100, word address of register 0 on the dma_io bus.
REQ-003 SHALL have port clk, input, 1: single clock, shared with the CPU and io_led.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port dma_io_we, input, 1: IO write strobe.
REQ-006 SHALL have port dma_io_wadr, input, [15:2]: IO write word address.
REQ-007 SHALL have port dma_io_wdata, input, 32: IO write data.
REQ-008 SHALL have port dma_io_radr, input, [15:2]: IO read word address.
REQ-009 SHALL have port dma_io_radr_en, input, 1: IO read strobe.
REQ-010 SHALL have port dma_io_rdata_in, input, 32: read data from the previous IO block in the chain.
REQ-011 SHALL have port dma_io_rdata, output, 32: read data toward the CPU or the next IO block.
REQ-012 SHALL have port uart_in_char, input, 8: received byte from the UART receiver.
REQ-013 SHALL have port uart_in_we, input, 1: one-cycle pulse that uart_in_char is valid.
REQ-014 SHALL have port rx_irq, output, 1: level interrupt request to the CPU.

Function
REQ-015 SHALL decode three registers: DATA at BASE_ADR (read-only), STATUS at BASE_ADR+1 (read-only) and CTRL at BASE_ADR+2 (read/write).
REQ-016 SHALL push uart_in_char on a uart_in_we cycle when the FIFO is not full.
REQ-017 SHALL, on uart_in_we while the FIFO is full with no pop that cycle, drop the byte and set a sticky overrun flag.
REQ-018 SHALL pop the FIFO on a dma_io_radr_en cycle addressing DATA when the FIFO is non-empty.
  - DATA read returns {23'b0, 1'b1, byte}.
  - When the FIFO is empty, the read returns 32'h0, with no pointer change.
REQ-019 SHALL, on a simultaneous push and pop, including while full, perform both and leave count unchanged, with no overrun.
REQ-020 SHALL keep read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-021 SHALL return STATUS as:
  - bit0 = not_empty
  - bit1 = full
  - bit2 = overrun
  - bits[14:8] = count
  - all other bits 0
REQ-022 SHALL implement CTRL as:
  - bit0 = irq_en (read/write).
  - bit1 = write-1 clears overrun; reads as 0.
  - bit2 = write-1 flushes the FIFO (pointers and count to 0); reads as 0.
REQ-023 SHALL, when a flush and a push occur in the same cycle, flush first and then store the pushed byte, giving count=1.
REQ-024 SHALL register read data with one-cycle latency.
  - Capture is on the dma_io_radr_en cycle.
  - dma_io_rdata = local data while the registered hit flag is set, otherwise dma_io_rdata_in passed combinationally.
REQ-025 SHALL drive rx_irq registered, equal to irq_en & not_empty, one cycle after the state change.
REQ-026 SHALL ignore writes to DATA and STATUS and accesses outside the three register addresses.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear pointers, count, overrun, irq_en, the read-hit flag, the read-data register and rx_irq to 0.
REQ-028 SHALL NOT reset FIFO storage contents, which are don't-care until written.

Structure
REQ-029 SHALL place register offsets (DATA=0, STATUS=1, CTRL=2) and the STATUS/CTRL bit positions in a shared io_pkg package.
REQ-030 SHALL instantiate a single sub-module, sync_fifo, parameterized by width 8 and FIFO_DEPTH, exposing push, pop, flush, full, empty and count.
REQ-031 SHALL be placed in the fpga_top dma_io read-data chain after io_uart_out.

Verification
REQ-032 SHALL cover: reset, then push 0x41 -> STATUS reads 0x00000101 and rx_irq stays 0 with irq_en=0; set CTRL=1 -> rx_irq=1 one cycle later.
REQ-033 SHALL cover: push 0x41, 0x42, then two DATA reads -> 0x00000141 then 0x00000142; a third read -> 0x00000000, and STATUS reads 0x0.
REQ-034 SHALL cover: push 17 bytes into depth 16 -> STATUS reads 0x00001007 (count 16, full, overrun, not_empty); CTRL=2 -> STATUS reads 0x00001003.
REQ-035 SHALL cover: full FIFO with simultaneous push 0x55 and DATA pop -> overrun stays 0, count stays 16, and 0x55 is read last after wrap-around.
REQ-036 SHALL cover: a read of an address outside the block with dma_io_rdata_in=0xDEADBEEF -> dma_io_rdata=0xDEADBEEF.
REQ-037 SHALL cover: rst_n asserted mid-fill (count 5) -> count 0 and rx_irq 0 immediately, and the next STATUS read returns 0.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO register offsets, bit positions and address decode
package io_pkg;

  localparam int unsigned REG_DATA_OFS   = 0;
  localparam int unsigned REG_STATUS_OFS = 1;
  localparam int unsigned REG_CTRL_OFS   = 2;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_CLR_OVR = 1;
  localparam int unsigned CTRL_FLUSH   = 2;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_adr(input logic [13:0] adr, input logic [13:0] base);
    logic [13:0] ofs;
    ofs = adr - base;
    case (ofs)
      14'(REG_DATA_OFS):   return SEL_DATA;
      14'(REG_STATUS_OFS): return SEL_STATUS;
      14'(REG_CTRL_OFS):   return SEL_CTRL;
      default:             return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; caller guards push/pop against full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
  logic [CW-1:0]    count_q, count_d;

  // A flush in the same cycle as a push restarts the FIFO with that byte at slot 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_idx   = wr_ptr_q;
    if (flush) begin
      wr_idx   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = {{(AW-1){1'b0}}, push};
      count_d  = {{(CW-1){1'b0}}, push};
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/io_uart_in.sv
// rtl/io_uart_in.sv - UART receive FIFO with DATA/STATUS/CTRL registers on the dma_io chain
module io_uart_in
  import io_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [13:0] BASE_ADR   = 14'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic [7:0]  uart_in_char,
  input  logic        uart_in_we,
  output logic        rx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e        wsel, rsel;
  logic            ctrl_wr, flush, clr_ovr, pop, push, full, empty;
  logic [7:0]      head;
  logic [CW-1:0]   count;
  logic            overrun_q, overrun_d, irq_en_q, irq_en_d;
  logic            hit_q, hit_d, rx_irq_q, rx_irq_d;
  logic [31:0]     rdata_q, rdata_d, rd_val, status;
  logic            unused_wdata;

  assign unused_wdata = ^dma_io_wdata[31:3];

  always_comb begin
    wsel    = decode_adr(dma_io_wadr, BASE_ADR);
    rsel    = decode_adr(dma_io_radr, BASE_ADR);
    ctrl_wr = dma_io_we && (wsel == SEL_CTRL);
    flush   = ctrl_wr && dma_io_wdata[CTRL_FLUSH];
    clr_ovr = ctrl_wr && dma_io_wdata[CTRL_CLR_OVR];
    pop     = dma_io_radr_en && (rsel == SEL_DATA) && !empty;
    // A pop or flush in the same cycle frees a slot, so a full FIFO still accepts the byte.
    push    = uart_in_we && (!full || pop || flush);

    overrun_d = (overrun_q && !clr_ovr) || (uart_in_we && !push);
    irq_en_d  = ctrl_wr ? dma_io_wdata[CTRL_IRQ_EN] : irq_en_q;
    rx_irq_d  = irq_en_q && !empty;

    status               = '0;
    status[ST_NOT_EMPTY] = !empty;
    status[ST_FULL]      = full;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_COUNT_LSB +: CW] = count;

    case (rsel)
      SEL_DATA:   rd_val = empty ? 32'h0 : {23'b0, 1'b1, head};
      SEL_STATUS: rd_val = status;
      SEL_CTRL:   rd_val = {31'b0, irq_en_q};
      default:    rd_val = 32'h0;
    endcase

    hit_d   = dma_io_radr_en && (rsel != SEL_NONE);
    rdata_d = dma_io_radr_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= 32'h0;
      rx_irq_q  <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      hit_q     <= hit_d;
      rdata_q   <= rdata_d;
      rx_irq_q  <= rx_irq_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (uart_in_char),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
  assign rx_irq       = rx_irq_q;

endmodule
